// File: rtl/seg_shift_tx.sv
// seg_shift_tx -- serial transmitter for the seven-segment display board.
//
// Captures a 64-bit segment/image word and shifts it MSB-first into the
// board's external shift-register chain using a divided shift clock, then
// pulses the storage latch so the new pattern appears atomically.
//
// Parameters:
//   CLK_DIV   clk cycles per seg_clk half-period (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   data       64-bit word, bit 63 shifted first
//   start      transfer request, sampled only while idle
//   seg_clk    shift clock to the board (board samples on rising edge)
//   seg_dout   serial data
//   seg_latch  storage-register latch pulse, active-high
//   busy       high from accepted start until the end of the latch phase
//   done       one-cycle pulse on return to idle after a full transfer
//
// Optional feature macro: SEG_AUTO_REFRESH_EN
//   When defined, a last_sent register remembers the last transferred word and
//   any difference between data and last_sent starts a transfer while idle.

module seg_shift_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data,
    input  logic        start,
    output logic        seg_clk,
    output logic        seg_dout,
    output logic        seg_latch,
    output logic        busy,
    output logic        done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [63:0]   shreg, shreg_nxt;
    logic [5:0]    bitcnt, bitcnt_nxt;
    logic [DW-1:0] div, div_nxt;
    logic          sclk_q, sclk_nxt;
    logic          done_q, done_nxt;
    logic          go;

`ifdef SEG_AUTO_REFRESH_EN
    logic [63:0] last_sent;

    // A word that differs from what the board last received acts as a start.
    assign go = start | (data != last_sent);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_sent <= '0;
        end else if (state == IDLE && go) begin
            last_sent <= data;
        end
    end
`else
    assign go = start;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            div    <= '0;
            sclk_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt_nxt;
            div    <= div_nxt;
            sclk_q <= sclk_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        div_nxt    = div;
        sclk_nxt   = sclk_q;
        done_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nxt  = SHIFT;
                    shreg_nxt  = data;
                    bitcnt_nxt = 6'd63;
                    div_nxt    = '0;
                    sclk_nxt   = 1'b0;
                end
            end

            SHIFT: begin
                if (div == DIV_MAX) begin
                    div_nxt = '0;
                    if (sclk_q) begin
                        // End of the high phase: the board has sampled this bit,
                        // so move on to the next one (or finish).
                        sclk_nxt = 1'b0;
                        if (bitcnt == 6'd0) begin
                            state_nxt = LATCH;
                        end else begin
                            shreg_nxt  = {shreg[62:0], 1'b0};
                            bitcnt_nxt = bitcnt - 6'd1;
                        end
                    end else begin
                        sclk_nxt = 1'b1;
                    end
                end else begin
                    div_nxt = div + DW'(1);
                end
            end

            LATCH: begin
                // Divider was cleared on entry, so the latch lasts CLK_DIV cycles.
                if (div == DIV_MAX) begin
                    div_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    div_nxt = div + DW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign seg_clk   = sclk_q;
    // Data line is held low outside the shift phase.
    assign seg_dout  = (state == SHIFT) & shreg[63];
    assign seg_latch = (state == LATCH);
    assign busy      = (state != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_seg_shift_tx.sv
// Self-checking bench for seg_shift_tx. Two instances (CLK_DIV=2 and 1) are
// driven independently; every cycle of a transfer is compared against a model
// that derives the expected pins from the cycle number since acceptance.

module tb_seg_shift_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [63:0] data0 = '0, data1 = '0;
    logic        sclk0, dout0, lat0, busy0, done0;
    logic        sclk1, dout1, lat1, busy1, done1;

    int n_chk  = 0;
    int n_fail = 0;

    seg_shift_tx #(.CLK_DIV(2)) u_d2 (
        .clk(clk), .rst(rst), .data(data0), .start(start0),
        .seg_clk(sclk0), .seg_dout(dout0), .seg_latch(lat0),
        .busy(busy0), .done(done0)
    );

    seg_shift_tx #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .data(data1), .start(start1),
        .seg_clk(sclk1), .seg_dout(dout1), .seg_latch(lat1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // {seg_clk, seg_dout, seg_latch, busy, done}
    function automatic logic [4:0] smp(input int k);
        return (k == 0) ? {sclk0, dout0, lat0, busy0, done0}
                        : {sclk1, dout1, lat1, busy1, done1};
    endfunction

    task automatic drv(input int k, input logic s, input logic [63:0] d);
        if (k == 0) begin
            start0 = s;
            data0  = d;
        end else begin
            start1 = s;
            data1  = d;
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Called at a negedge with start/data already driven so the next posedge
    // is the accept edge (cycle 0). Checks cycles 1..129*D+1.
    // mode 0: random start/data during the transfer, start=0 and data=w at the end
    // mode 1: start held 1, data random every cycle (back-to-back)
    // mode 2: start 0, data held at w
    task automatic xfer(input int k, input logic [63:0] w, input int mode,
                        output logic [63:0] nxt);
        int          d_div;
        int          last;
        int          b;
        int          rises;
        logic        ec;
        logic        pc;
        logic [4:0]  o;
        logic [63:0] rec;
        logic        s;
        logic [63:0] d;
        d_div = div_of(k);
        last  = 129 * d_div + 1;
        rises = 0;
        rec   = '0;
        pc    = 1'b0;
        nxt   = w;
        @(posedge clk);
        @(negedge clk);
        for (int t = 1; t <= last; t++) begin
            o = smp(k);
            if (t <= 128 * d_div) begin
                b  = (t - 1) / (2 * d_div);
                ec = (((t - 1) % (2 * d_div)) >= d_div);
                chk($sformatf("k%0d seg_clk@%0d", k, t), 64'(o[4]), 64'(ec));
                chk($sformatf("k%0d seg_dout@%0d", k, t), 64'(o[3]), 64'(w[63-b]));
                chk($sformatf("k%0d seg_latch@%0d", k, t), 64'(o[2]), 64'd0);
                chk($sformatf("k%0d busy@%0d", k, t), 64'(o[1]), 64'd1);
                chk($sformatf("k%0d done@%0d", k, t), 64'(o[0]), 64'd0);
            end else if (t <= 129 * d_div) begin
                chk($sformatf("k%0d seg_clk@%0d", k, t), 64'(o[4]), 64'd0);
                chk($sformatf("k%0d seg_latch@%0d", k, t), 64'(o[2]), 64'd1);
                chk($sformatf("k%0d busy@%0d", k, t), 64'(o[1]), 64'd1);
                chk($sformatf("k%0d done@%0d", k, t), 64'(o[0]), 64'd0);
            end else begin
                chk($sformatf("k%0d seg_clk@%0d", k, t), 64'(o[4]), 64'd0);
                chk($sformatf("k%0d seg_latch@%0d", k, t), 64'(o[2]), 64'd0);
                chk($sformatf("k%0d busy@%0d", k, t), 64'(o[1]), 64'd0);
                chk($sformatf("k%0d done@%0d", k, t), 64'(o[0]), 64'd1);
            end
            if (!pc && o[4]) begin
                rises++;
                rec = {rec[62:0], o[3]};
            end
            pc = o[4];
            case (mode)
                0: begin
                    s = (t < last) ? 1'($urandom_range(0, 1)) : 1'b0;
                    d = (t < last) ? rnd64() : w;
                end
                1: begin
                    s = 1'b1;
                    d = rnd64();
                end
                default: begin
                    s = 1'b0;
                    d = w;
                end
            endcase
            drv(k, s, d);
            nxt = d;
            if (t < last) @(negedge clk);
        end
        chk($sformatf("k%0d rises", k), 64'(rises), 64'd64);
        chk($sformatf("k%0d word", k), rec, w);
    endtask

    task automatic idle(input int k, input int n);
        logic [4:0] o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = smp(k);
            chk($sformatf("k%0d idle_out", k), 64'(o), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] w;
        logic [63:0] nx;
        logic [4:0]  o;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_k0", 64'(smp(0)), 64'd0);
        chk("rst_out_k1", 64'(smp(1)), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single marker bits at both ends, CLK_DIV=2
        w = 64'h8000_0000_0000_0001;
        drv(0, 1'b1, w);
        xfer(0, w, 0, nx);
        idle(0, 10);

        // Mixed pattern, CLK_DIV=1
        w = 64'hA5A5_0F0F_3C3C_FFFF;
        drv(1, 1'b1, w);
        xfer(1, w, 0, nx);
        idle(1, 5);

        // Random words on both dividers, with start/data noise while busy
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2; k++) begin
                w = rnd64();
                drv(k, 1'b1, w);
                xfer(k, w, 0, nx);
                idle(k, 3);
            end
        end

        // Back-to-back with start held high and data changing every cycle
        for (int k = 0; k < 2; k++) begin
            w = rnd64();
            drv(k, 1'b1, w);
            for (int i = 0; i < 3 - k; i++) begin
                xfer(k, w, 1, nx);
                w = nx;
            end
            xfer(k, w, 0, nx);
            idle(k, 5);
        end

        // Reset in the middle of a transfer
        w = rnd64();
        drv(0, 1'b1, w);
        @(posedge clk);
        @(negedge clk);
        drv(0, 1'b0, w);
        repeat (99) @(negedge clk);
        o = smp(0);
        chk("mid_busy", 64'(o[1]), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_k0", 64'(smp(0)), 64'd0);
        chk("rst_async_k1", 64'(smp(1)), 64'd0);
        drv(0, 1'b0, 64'd0);
        idle(0, 3);
        rst = 1'b1;
        idle(0, 300);
        w = rnd64();
        drv(0, 1'b1, w);
        xfer(0, w, 0, nx);
        idle(0, 5);

`ifdef SEG_AUTO_REFRESH_EN
        // Auto refresh with start tied low
        drv(0, 1'b0, 64'd0);
        idle(0, 5);
        drv(0, 1'b0, 64'h1234);
        xfer(0, 64'h1234, 2, nx);
        idle(0, 300);
`else
        // Data changes without start must not launch a transfer
        for (int i = 0; i < 20; i++) begin
            drv(0, 1'b0, rnd64());
            @(negedge clk);
            o = smp(0);
            chk("no_start_busy", 64'(o[1]), 64'd0);
        end
        drv(0, 1'b0, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_shift_tx.md
# seg_shift_tx

Serial transmitter for the seven-segment display board. It takes the 64-bit segment/image word produced by the display I/O device and shifts it MSB-first into the board's external shift-register chain. It drives a divided shift clock and serial data, then pulses a latch so the new pattern appears atomically. It sits between the GPIO display device and the board pins, and is the output end of the segment-data path.

## Interface

Parameters:
- CLK_DIV, 2: clk cycles per seg_clk half-period; legal range ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- data  input  64  segment/image word; bit 63 is shifted first.
- start  input  1  transfer request; sampled only in IDLE.
- seg_clk  output  1  shift clock to the board; the board samples seg_dout on its rising edge.
- seg_dout  output  1  serial data.
- seg_latch  output  1  storage-register latch pulse, active-high.
- busy  output  1  high from the accepted start until the end of LATCH.
- done  output  1  one-cycle pulse on return to IDLE after a full transfer.

## Operation

Reset values: every output is 0 (seg_clk, seg_dout, seg_latch, busy, done). State is IDLE, and the shift register and counters are cleared.

States:
- IDLE
  - If start=1: copy data into the 64-bit shift register, load the bit counter with 63, clear the divider, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT
  - seg_dout is always shreg[63].
  - The divider counts from 0 to CLK_DIV-1 and seg_clk toggles at each wrap. Each bit therefore gets one low phase and one high phase.
  - At the end of a high phase (seg_clk falling): if the bit counter is 0, go to LATCH. Otherwise shift shreg left by one and decrement the bit counter.
- LATCH
  - seg_clk=0 and seg_latch=1 for CLK_DIV cycles, then go to IDLE.
  - On that transition, done=1 for exactly one cycle and busy=0.

Rules:
- start while busy is ignored; it is neither queued nor able to corrupt the transfer.
- data may change freely after it is captured, because only the captured copy is shifted.
- start can be accepted in the same cycle that done is high, which makes back-to-back transfers possible.
- rst asserted mid-transfer: outputs return to reset values immediately and the latch is not pulsed. The board keeps its previous pattern.
- Divider width is max(1, $clog2(CLK_DIV)) and the bit counter is 6 bits. Neither counter may wrap except as specified above.

## Timing

Cycle numbering: cycle 0 is the edge where start=1 is sampled in IDLE.

- Cycle 1: busy=1, seg_clk=0, seg_dout=data[63].
- seg_clk rises after CLK_DIV cycles and falls after 2·CLK_DIV cycles.
- seg_dout changes only at seg_clk falling edges, never on a rising edge.
- seg_clk period: 2·CLK_DIV cycles; total SHIFT duration: 128·CLK_DIV cycles.
- seg_latch high: cycles 1+128·CLK_DIV through 128·CLK_DIV+CLK_DIV.
- done=1 and busy=0: cycle 1+129·CLK_DIV.
- Worked example, CLK_DIV=2: 64 seg_clk rising edges, latch high during cycles 257–258, done in cycle 259.

## Configuration

- SEG_AUTO_REFRESH_EN defined:
  - Add a 64-bit last_sent register, reset to 0, loaded with the captured word at each accepted transfer.
  - In IDLE, data != last_sent acts as an internal start, so the display follows data without software strobes.
  - The external start still works.
- SEG_AUTO_REFRESH_EN undefined: no last_sent register; transfers occur only on start.

## Test plan

- Reset, CLK_DIV=2, data=64'h8000_0000_0000_0001, pulse start in cycle 0:
  - seg_dout=1 on the 1st and 64th seg_clk rising edges and 0 on all others.
  - 64 rising edges in total.
  - seg_latch high in cycles 257–258.
  - done a single pulse in cycle 259.
- data=64'hA5A5_0F0F_3C3C_FFFF, CLK_DIV=1:
  - The bench samples seg_dout on seg_clk rising edges and reconstructs exactly A5A5_0F0F_3C3C_FFFF.
  - done in cycle 130.
- start held high continuously with data changing every cycle:
  - Each transfer carries the word present at its accept cycle.
  - The next transfer is accepted in the same cycle as done, with no gap.
- rst driven low at cycle 100 of a transfer:
  - All outputs go to 0 immediately, with no seg_latch pulse.
  - After release, start transfers normally.
- SEG_AUTO_REFRESH_EN defined, start tied 0:
  - data=0 after reset: no transfer.
  - data set to 64'h1234: one transfer begins the next cycle.
  - data held at 64'h1234 afterwards: no further transfers.
